// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-buffer constants and capture-state type
package uart_pkg;
    localparam int RX_BUF_DEPTH = 16;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} rx_buf_state_t;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x 8 storage, synchronous write, asynchronous read
module rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    din,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    dout
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= din;
    assign dout = mem[raddr];
endmodule

// File: rtl/rx_buffer.sv
// rx_buffer: captures UART receiver bytes via an rda/rx_read_en handshake into a
// first-word fall-through FIFO with sticky overrun on drop
module rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rda,
    input  logic [7:0]               rx_byte,
    output logic                     rx_read_en,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clr_overrun
);
    localparam int AW = $clog2(DEPTH);
    rx_buf_state_t state;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic capture, push, take;
    assign capture = state == IDLE && rda;
    assign take = pop && !empty;
    // a full FIFO still accepts the byte when the head leaves in the same cycle
    assign push = capture && (!full || pop);
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rx_read_en <= 1'b0;
        end else begin
            state <= capture ? ACK :
                     state == ACK ? WAIT_LOW :
                     (state == WAIT_LOW && !rda) ? IDLE : state;
            rx_read_en <= capture;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overrun <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(take);
            count <= count + (AW+1)'(push) - (AW+1)'(take);
            overrun <= (capture && full && !pop) ? 1'b1 : clr_overrun ? 1'b0 : overrun;
        end
    end
    rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(push),
        .waddr(wr_ptr),
        .din(rx_byte),
        .raddr(rd_ptr),
        .dout(dout)
    );
endmodule
